// File: rtl/seven_segment_reader_pkg.sv
// Shared constants for the seven-segment reader: active-low segment patterns
// (bit6=a .. bit0=g) and the special codes reported for dash and unknown patterns.
package seven_segment_reader_pkg;

    localparam logic [6:0] SEG_0    = 7'b0000001;
    localparam logic [6:0] SEG_1    = 7'b1001111;
    localparam logic [6:0] SEG_2    = 7'b0010010;
    localparam logic [6:0] SEG_3    = 7'b0000110;
    localparam logic [6:0] SEG_4    = 7'b1001100;
    localparam logic [6:0] SEG_5    = 7'b0100100;
    localparam logic [6:0] SEG_6    = 7'b0100000;
    localparam logic [6:0] SEG_7    = 7'b0001111;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0000100;
    localparam logic [6:0] SEG_DASH = 7'b1111110;

    localparam logic [3:0] CODE_DASH    = 4'hE;
    localparam logic [3:0] CODE_INVALID = 4'hF;

    localparam int IDX_W = 3;

endpackage

// File: rtl/seven_segment_pattern_to_code.sv
// Purely combinational lookup from an active-low segment pattern to its digit code.
module seven_segment_pattern_to_code
    import seven_segment_reader_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] code_o
);

    // Table lookup; anything not in the table reports CODE_INVALID
    always_comb begin
        code_o = CODE_INVALID;
        case (pattern_i)
            SEG_0:    code_o = 4'h0;
            SEG_1:    code_o = 4'h1;
            SEG_2:    code_o = 4'h2;
            SEG_3:    code_o = 4'h3;
            SEG_4:    code_o = 4'h4;
            SEG_5:    code_o = 4'h5;
            SEG_6:    code_o = 4'h6;
            SEG_7:    code_o = 4'h7;
            SEG_8:    code_o = 4'h8;
            SEG_9:    code_o = 4'h9;
            SEG_DASH: code_o = CODE_DASH;
            default:  code_o = CODE_INVALID;
        endcase
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Passive monitor of a multiplexed seven-segment bus: recovers each digit's code
// once its (anode, segment) sample has been stable for STABLE_CYCLES cycles.
module seven_segment_reader
    import seven_segment_reader_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                segment,
    input  logic [NUM_DIGITS-1:0]     anode,
    input  logic                      clear_err,
    output logic [4*NUM_DIGITS-1:0]   digit_values,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      update,
    output logic [IDX_W-1:0]          update_idx,
    output logic                      err_invalid
);

    localparam int                RUN_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX    = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0]  RUN_COMMIT = RUN_W'(STABLE_CYCLES - 1);

    logic [3:0]              live_code_s;
    logic [3:0]              low_cnt_s;
    logic                    anode_legal_s;
    logic [IDX_W-1:0]        anode_idx_s;
    logic                    same_s;
    logic                    commit_s;

    logic [NUM_DIGITS-1:0]   prev_anode_q, prev_anode_d;
    logic [6:0]              prev_seg_q,   prev_seg_d;
    logic [RUN_W-1:0]        run_q,        run_d;
    logic [4*NUM_DIGITS-1:0] values_q,     values_d;
    logic [NUM_DIGITS-1:0]   valid_q,      valid_d;
    logic                    update_q,     update_d;
    logic [IDX_W-1:0]        idx_q,        idx_d;
    logic                    err_q,        err_d;

    seven_segment_pattern_to_code u_decode (
        .pattern_i (segment),
        .code_o    (live_code_s)
    );

    // Anode qualification: count low strobes and encode the position of the low one
    always_comb begin
        low_cnt_s   = 4'd0;
        anode_idx_s = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!anode[i]) begin
                low_cnt_s   = low_cnt_s + 4'd1;
                anode_idx_s = IDX_W'(i);
            end else begin
                low_cnt_s   = low_cnt_s;
                anode_idx_s = anode_idx_s;
            end
        end
        anode_legal_s = (low_cnt_s == 4'd1);
    end

    // Run tracking and commit detection; a run commits only on its STABLE_CYCLES-1 -> STABLE_CYCLES step
    always_comb begin
        prev_anode_d = anode;
        prev_seg_d   = segment;
        same_s       = anode_legal_s && (anode == prev_anode_q) && (segment == prev_seg_q);
        commit_s     = same_s && (run_q == RUN_COMMIT);
        if (same_s) begin
            run_d = (run_q == RUN_MAX) ? RUN_MAX : (run_q + RUN_W'(1));
        end else if (anode_legal_s) begin
            run_d = RUN_W'(1);
        end else begin
            run_d = {RUN_W{1'b0}};
        end
    end

    // Commit effects on per-digit storage, pulse, index and sticky error (set beats clear)
    always_comb begin
        values_d = values_q;
        valid_d  = valid_q;
        update_d = 1'b0;
        idx_d    = idx_q;
        if (commit_s) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (anode_idx_s == IDX_W'(i)) begin
                    values_d[4*i +: 4] = live_code_s;
                    valid_d[i]         = 1'b1;
                end else begin
                    values_d[4*i +: 4] = values_q[4*i +: 4];
                    valid_d[i]         = valid_q[i];
                end
            end
            update_d = 1'b1;
            idx_d    = anode_idx_s;
        end else begin
            update_d = 1'b0;
        end

        if (commit_s && (live_code_s == CODE_INVALID)) begin
            err_d = 1'b1;
        end else if (clear_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_anode_q <= {NUM_DIGITS{1'b1}};
            prev_seg_q   <= 7'h7F;
            run_q        <= {RUN_W{1'b0}};
            values_q     <= {(4*NUM_DIGITS){1'b1}};
            valid_q      <= {NUM_DIGITS{1'b0}};
            update_q     <= 1'b0;
            idx_q        <= {IDX_W{1'b0}};
            err_q        <= 1'b0;
        end else begin
            prev_anode_q <= prev_anode_d;
            prev_seg_q   <= prev_seg_d;
            run_q        <= run_d;
            values_q     <= values_d;
            valid_q      <= valid_d;
            update_q     <= update_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
        end
    end

    assign digit_values = values_q;
    assign digit_valid  = valid_q;
    assign update       = update_q;
    assign update_idx   = idx_q;
    assign err_invalid  = err_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Self-checking bench for seven_segment_reader: history-window reference model
// compared every cycle, plus directed checks against hand-computed codes.
module tb_seven_segment_reader;

    localparam int ND = 4;
    localparam int SC = 4;

    localparam logic [6:0] PAT  [11] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                         7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                         7'b0000000, 7'b0000100, 7'b1111110};
    localparam logic [3:0] CODE [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                         4'h6, 4'h7, 4'h8, 4'h9, 4'hE};

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [6:0]      segment = 7'h7F;
    logic [ND-1:0]   anode = 4'hF;
    logic            clear_err = 1'b0;
    logic [4*ND-1:0] digit_values;
    logic [ND-1:0]   digit_valid;
    logic            update;
    logic [2:0]      update_idx;
    logic            err_invalid;

    int vectors = 0;
    int miscompares = 0;
    int upd_cnt = 0;

    seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk          (clk),
        .reset        (reset),
        .segment      (segment),
        .anode        (anode),
        .clear_err    (clear_err),
        .digit_values (digit_values),
        .digit_valid  (digit_valid),
        .update       (update),
        .update_idx   (update_idx),
        .err_invalid  (err_invalid)
    );

    always #5 clk = ~clk;

    // Reference model: a commit happens when the last SC samples are identical with one
    // low anode and the sample just before them differs (or predates reset).
    logic [ND-1:0]   h_an [SC+1];
    logic [6:0]      h_sg [SC+1];
    bit              h_ok [SC+1];
    logic [3:0]      m_val [ND];
    logic [ND-1:0]   m_valid;
    logic            m_upd;
    logic [2:0]      m_idx;
    logic            m_err;
    bit              m_commit;
    int              m_zeros;
    int              m_pos;
    logic [3:0]      m_code;
    logic [4*ND-1:0] exp_vec;

    function automatic logic [3:0] ref_decode(input logic [6:0] s);
        ref_decode = 4'hF;
        for (int k = 0; k < 11; k++)
            if (PAT[k] == s) ref_decode = CODE[k];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= SC; k++) h_ok[k] = 1'b0;
            for (int d = 0; d < ND; d++) m_val[d] = 4'hF;
            m_valid = '0;
            m_upd   = 1'b0;
            m_idx   = 3'd0;
            m_err   = 1'b0;
        end else begin
            for (int k = SC; k > 0; k--) begin
                h_an[k] = h_an[k-1];
                h_sg[k] = h_sg[k-1];
                h_ok[k] = h_ok[k-1];
            end
            h_an[0] = anode;
            h_sg[0] = segment;
            h_ok[0] = 1'b1;
            m_zeros = 0;
            m_pos   = 0;
            for (int d = 0; d < ND; d++)
                if (anode[d] == 1'b0) begin
                    m_zeros++;
                    m_pos = d;
                end
            m_commit = (m_zeros == 1);
            for (int k = 1; k < SC; k++)
                if (!h_ok[k] || h_an[k] != h_an[0] || h_sg[k] != h_sg[0]) m_commit = 1'b0;
            if (h_ok[SC] && h_an[SC] == h_an[0] && h_sg[SC] == h_sg[0]) m_commit = 1'b0;
            m_code = ref_decode(segment);
            m_upd  = m_commit;
            if (m_commit) begin
                m_val[m_pos]   = m_code;
                m_valid[m_pos] = 1'b1;
                m_idx          = 3'(m_pos);
            end
            if (m_commit && m_code == 4'hF) m_err = 1'b1;
            else if (clear_err)             m_err = 1'b0;
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) exp_vec[4*d +: 4] = m_val[d];
        vectors++;
        if (digit_values !== exp_vec || digit_valid !== m_valid || update !== m_upd ||
            update_idx !== m_idx || err_invalid !== m_err) begin
            miscompares++;
            $display("FAIL cycle_compare t=%0t: got vals=%h valid=%b upd=%b idx=%0d err=%b, expected vals=%h valid=%b upd=%b idx=%0d err=%b",
                     $time, digit_values, digit_valid, update, update_idx, err_invalid,
                     exp_vec, m_valid, m_upd, m_idx, m_err);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] an, input logic [6:0] sg, input logic clr);
        anode     = an;
        segment   = sg;
        clear_err = clr;
        @(posedge clk);
        #1;
        if (update === 1'b1) upd_cnt++;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int u0;
    logic [3:0] r_an;
    logic [6:0] r_sg;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_values", 32'(digit_values), 32'hFFFF);
        check("reset_valid", 32'(digit_valid), 32'h0);
        check("reset_update", 32'(update), 32'h0);
        check("reset_err", 32'(err_invalid), 32'h0);
        reset = 1'b0;
        u0 = upd_cnt;
        repeat (10) step(4'b1111, 7'($urandom), 1'b0);
        check("idle_no_update", 32'(upd_cnt - u0), 32'd0);

        // Full table on digit 2
        for (int p = 0; p < 11; p++) begin
            repeat (3) step(4'b1011, PAT[p], 1'b0);
            check("table_early", 32'(update), 32'h0);
            step(4'b1011, PAT[p], 1'b0);
            check("table_pulse", 32'(update), 32'h1);
            check("table_idx", 32'(update_idx), 32'd2);
            check("table_code", 32'(digit_values[11:8]), 32'(CODE[p]));
            u0 = upd_cnt;
            repeat (6) step(4'b1011, PAT[p], 1'b0);
            check("table_no_repeat", 32'(upd_cnt - u0), 32'd0);
        end

        // Glitch rejection on digit 0
        repeat (4) step(4'b1110, 7'b0010010, 1'b0);
        check("glitch_base", 32'(digit_values[3:0]), 32'h2);
        u0 = upd_cnt;
        repeat (3) begin
            step(4'b1110, 7'b0000110, 1'b0);
            check("glitch_hold", 32'(digit_values[3:0]), 32'h2);
        end
        repeat (3) begin
            step(4'b1110, 7'b0010010, 1'b0);
            check("glitch_return_quiet", 32'(update), 32'h0);
        end
        step(4'b1110, 7'b0010010, 1'b0);
        check("glitch_recommit", 32'(update), 32'h1);
        repeat (4) step(4'b1110, 7'b0010010, 1'b0);
        check("glitch_pulse_count", 32'(upd_cnt - u0), 32'd1);
        check("glitch_value", 32'(digit_values[3:0]), 32'h2);

        // Invalid pattern and sticky error
        repeat (4) step(4'b1101, 7'b1010101, 1'b0);
        check("invalid_code", 32'(digit_values[7:4]), 32'hF);
        check("invalid_err", 32'(err_invalid), 32'h1);
        repeat (3) step(4'b1101, 7'b1111111, 1'b0);
        step(4'b1101, 7'b1111111, 1'b1);
        check("set_beats_clear_pulse", 32'(update), 32'h1);
        check("set_beats_clear", 32'(err_invalid), 32'h1);
        step(4'b1101, 7'b1111111, 1'b1);
        check("clear_err", 32'(err_invalid), 32'h0);
        step(4'b1101, 7'b1111111, 1'b0);

        // Illegal anode
        u0 = upd_cnt;
        repeat (10) step(4'b1001, 7'($urandom), 1'b0);
        repeat (10) step(4'b1111, 7'($urandom), 1'b0);
        check("illegal_no_update", 32'(upd_cnt - u0), 32'd0);
        repeat (3) step(4'b0111, 7'b0000001, 1'b0);
        check("legal_early", 32'(update), 32'h0);
        step(4'b0111, 7'b0000001, 1'b0);
        check("legal_pulse", 32'(update), 32'h1);
        check("legal_idx", 32'(update_idx), 32'd3);

        // Reset mid-run
        repeat (2) step(4'b1110, 7'b1001111, 1'b0);
        reset_pulse();
        check("midrst_valid", 32'(digit_valid), 32'h0);
        check("midrst_update", 32'(update), 32'h0);
        repeat (3) begin
            step(4'b1110, 7'b1001111, 1'b0);
            check("midrst_quiet", 32'(update), 32'h0);
        end
        step(4'b1110, 7'b1001111, 1'b0);
        check("midrst_pulse", 32'(update), 32'h1);
        check("midrst_idx", 32'(update_idx), 32'd0);
        check("midrst_code", 32'(digit_values[3:0]), 32'h1);

        // Randomised runs checked by the model
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 9) == 0) r_an = 4'($urandom);
            else r_an = ~(4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) r_sg = 7'($urandom);
            else r_sg = PAT[$urandom_range(0, 10)];
            repeat ($urandom_range(1, 7)) step(r_an, r_sg, ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 49) == 0) reset_pulse();
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_segment_reader.md
Name: seven_segment_reader

Overview:
- Inverse of the counter seven-segment decoder.
- Passively monitors a multiplexed seven-segment bus (active-low segment lines plus active-low digit anode strobes) and recovers the numeric value shown on each digit.
- Each value is committed only after the bus has been stable for a programmable number of cycles.
- Used by the lock system for display self-check and attempt-counter readback.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (anode width); 1..8.
- STABLE_CYCLES, 4: consecutive identical (anode, segment) cycles required before a commit; minimum 2.

Ports:
- clk  input  1  system clock; all state rising-edge triggered.
- reset  input  1  asynchronous, active-high reset.
- segment  input  7  active-low segment lines, bit6=a … bit0=g.
- anode  input  NUM_DIGITS  active-low digit strobes; exactly one bit low selects a digit.
- clear_err  input  1  synchronous clear of err_invalid.
- digit_values  output  4*NUM_DIGITS  recovered code per digit; digit i occupies bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  bit i set once digit i has been committed at least once.
- update  output  1  one-cycle pulse on every commit.
- update_idx  output  3  digit index of the latest commit.
- err_invalid  output  1  sticky flag: a committed pattern was not in the table.

Behaviour:
- Reset (async, active-high):
  - digit_values = all 4'hF; digit_valid = 0; update = 0; update_idx = 0; err_invalid = 0.
  - Internal run counter = 0; previous-sample registers = all ones.
- Decode table (pattern -> code):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4.
  - 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9.
  - 1111110 (dash / blank default) -> 4'hE.
  - Any other pattern -> 4'hF.
- Anode qualification: legal only when exactly one bit of anode is 0. Illegal anode (none low or several low) forces run counter to 0; nothing is committed.
- Stability tracking, evaluated each clk edge:
  - If anode is legal and (anode, segment) equals the previous cycle's sample: run counter increments, saturating at STABLE_CYCLES.
  - Otherwise run counter loads 1 (legal anode) or 0 (illegal anode).
  - Previous-sample registers load the current (anode, segment) every cycle.
- Commit happens on the edge where the run counter transitions from STABLE_CYCLES-1 to STABLE_CYCLES. This is exactly once per stable run; a held pattern does not re-commit.
- Commit effects, all visible the cycle after that edge:
  - digit_values[idx] = decoded code.
  - digit_valid[idx] = 1.
  - update = 1 for that single cycle.
  - update_idx = idx.
- Latency: a pattern first present in cycle 0 and held updates outputs after the edge ending cycle STABLE_CYCLES-1. A change shorter than STABLE_CYCLES cycles never commits (glitch rejection).
- A new run on the same digit overwrites that digit's value; other digits are untouched.
- err_invalid:
  - Set on any commit whose code is 4'hF.
  - Cleared when clear_err=1.
  - Set and clear in the same cycle: set wins.
  - 4'hE (dash) is legal and does not set the error.
- Reset asserted mid-run: all state returns to reset values immediately. After release, a full STABLE_CYCLES run is required before the next commit.
- Index width: update_idx is fixed at 3 bits. Upper bits are 0 when NUM_DIGITS<8.

Decomposition:
- Shared package holds:
  - the eleven segment-pattern constants, identical to those used by the existing decoders;
  - code constants CODE_DASH=4'hE and CODE_INVALID=4'hF.
- Natural sub-module: seven_segment_pattern_to_code, a purely combinational 7-bit pattern to 4-bit code lookup. It is instantiated once on the live segment input.
- Top-level holds the anode one-hot checker, index encoder, run counter, per-digit registers and error flag.

Test Plan:
- Reset: with reset high, digit_values=16'hFFFF, digit_valid=0, update=0, err_invalid=0. Release, hold anode=4'b1111 for 10 cycles -> still no update.
- Full table: for each of the 11 table patterns on digit 2 (anode=4'b1011), hold 4 cycles. Expect update pulse after the 4th edge, update_idx=2, digit_values[11:8]=expected code (0–9, E). Hold 6 more cycles -> no second pulse.
- Glitch rejection: digit 0 steady on 0010010 (commits 2). Change to 0000110 for 3 cycles, then back -> digit 0 stays 2 throughout. Exactly one extra pulse (re-commit of 2) after the 4th stable cycle of the return.
- Invalid and error: hold 1010101 on digit 1 for 4 cycles -> digit_values[7:4]=F, err_invalid=1. Assert clear_err in the same cycle as a second invalid commit -> err_invalid stays 1. clear_err alone -> 0.
- Illegal anode: anode=4'b1001 or 4'b1111 with any segment for 20 cycles -> no update, run counter 0. Switch to legal 4'b0111 -> commit exactly 4 cycles later, update_idx=3.
- Reset mid-run: digit 0 stable on 1001111 for 2 cycles, then pulse reset 1 cycle -> no commit, digit_valid=0. After release with the same pattern held, commit occurs exactly 4 cycles later.
